// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared types and width helpers for the ESN readout
//
// Purpose : one-hot FSM encoding and width helpers used by readout_interpreter
//           and readout_mac_lane.
// Contents: state_t    IDLE/MAC/ACT/OUT one-hot state encoding
//           accWidth   accumulator width that cannot overflow over R products
//           addrWidth  weight/bias write-address width
package readout_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    MAC  = 4'b0010,
    ACT  = 4'b0100,
    OUT  = 4'b1000
  } state_t;

  // Full-precision product plus clog2(R) growth bits plus one guard bit.
  function automatic int accWidth(input int dataWidth, input int weightSize,
                                  input int reservoirSize);
    return dataWidth + weightSize + $clog2(reservoirSize) + 1;
  endfunction

  // Covers C*R weights plus C bias slots, so the address map is identical
  // whether or not the bias registers are built.
  function automatic int addrWidth(input int outChannels, input int reservoirSize);
    return $clog2(outChannels * reservoirSize + outChannels);
  endfunction

endpackage

// File: rtl/readout_mac_lane.sv
// rtl/readout_mac_lane.sv - one readout channel: accumulate, shift, saturate
//
// Ports:
//   iClk, iRst_n  clock, asynchronous active-low reset
//   iClear        load iPreload into the accumulator (start of a job)
//   iPreload      accumulator start value (bias or zero)
//   iMacEn        add iX*iW to the accumulator
//   iX, iW        signed reservoir element and weight for this cycle
//   iAct          register the hard-tanh of the accumulator into oValue
//   oValue        registered saturated result
module readout_mac_lane #(
  parameter int data_width  = 3,
  parameter int weight_size = 16,
  parameter int acc_width   = 22,
  parameter int act_shift   = 8,
  parameter int out_width   = 8
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic                        iClear,
  input  logic signed [acc_width-1:0] iPreload,
  input  logic                        iMacEn,
  input  logic signed [data_width-1:0]  iX,
  input  logic signed [weight_size-1:0] iW,
  input  logic                        iAct,
  output logic signed [out_width-1:0] oValue
);

  localparam int prodW = data_width + weight_size;

  // Clamp limits expressed at accumulator width so the compare is signed
  // and exact regardless of how far the shifted value overshoots.
  localparam logic signed [acc_width-1:0] satMax =
    {{(acc_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] satMin =
    {{(acc_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

  logic signed [acc_width-1:0] acc;
  logic signed [prodW-1:0]     prod;
  logic signed [acc_width-1:0] prodExt;
  logic signed [acc_width-1:0] shifted;

  assign prod    = iX * iW;
  assign prodExt = {{(acc_width-prodW){prod[prodW-1]}}, prod};
  assign shifted = acc >>> act_shift;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      acc    <= '0;
      oValue <= '0;
    end else begin
      if (iClear) begin
        acc <= iPreload;
      end else if (iMacEn) begin
        acc <= acc + prodExt;
      end

      if (iAct) begin
        if (shifted > satMax) begin
          oValue <= satMax[out_width-1:0];
        end else if (shifted < satMin) begin
          oValue <= satMin[out_width-1:0];
        end else begin
          oValue <= shifted[out_width-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/readout_interpreter.sv
// rtl/readout_interpreter.sv - multi-channel ESN readout with valid/ready output
//
// Optional feature: define READOUT_BIAS_EN to build per-channel bias registers
// at addresses C*R+c that are preloaded into the accumulators at start.
//
// Ports:
//   iClk, iRst_n  clock, asynchronous active-low reset
//   iEn           start request, sampled only in IDLE
//   iData         reservoir vector, element i at [i*data_width +: data_width]
//   iWe, iWAddr, iWData  weight (and bias) write port, honoured in IDLE/OUT
//   oValue        results, channel c at [c*out_width +: out_width]
//   oValid        oValue valid (held until accepted)
//   iReady        consumer accepts oValue
//   oBusy         high in MAC, ACT and OUT
module readout_interpreter
  import readout_pkg::*;
#(
  parameter int data_width     = 3,
  parameter int weight_size    = 16,
  parameter int reservoir_size = 4,
  parameter int out_channels   = 2,
  parameter int act_shift      = 8,
  parameter int out_width      = 8
) (
  input  logic                                    iClk,
  input  logic                                    iRst_n,
  input  logic                                    iEn,
  input  logic [reservoir_size*data_width-1:0]    iData,
  input  logic                                    iWe,
  input  logic [addrWidth(out_channels, reservoir_size)-1:0] iWAddr,
  input  logic [weight_size-1:0]                  iWData,
  output logic [out_channels*out_width-1:0]       oValue,
  output logic                                    oValid,
  input  logic                                    iReady,
  output logic                                    oBusy
);

  localparam int accW       = accWidth(data_width, weight_size, reservoir_size);
  localparam int addrW      = addrWidth(out_channels, reservoir_size);
  localparam int idxW       = $clog2(reservoir_size);
  localparam int numWeights = out_channels * reservoir_size;
`ifdef READOUT_BIAS_EN
  localparam int numRegs    = numWeights + out_channels;
`else
  localparam int numRegs    = numWeights;
`endif
  localparam logic [idxW-1:0] lastIdx = idxW'(reservoir_size - 1);

  state_t state, stateNext;
  logic   clearAcc, macEn, actEn;

  logic [reservoir_size*data_width-1:0] dataReg;
  logic [idxW-1:0]                      idx;
  logic signed [data_width-1:0]         xCur;
  logic                                 wrOk;

  // Sized to the full address space so every address is a legal index;
  // slots at or above numRegs are never written and stay zero.
  logic signed [weight_size-1:0] wRegs [2**addrW];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    clearAcc  = 1'b0;
    macEn     = 1'b0;
    actEn     = 1'b0;
    unique case (state)
      IDLE: begin
        if (iEn) begin
          clearAcc  = 1'b1;
          stateNext = MAC;
        end
      end
      MAC: begin
        macEn = 1'b1;
        if (idx == lastIdx) begin
          stateNext = ACT;
        end
      end
      ACT: begin
        actEn     = 1'b1;
        stateNext = OUT;
      end
      OUT: begin
        // A start on the accepting edge is dropped: IDLE must be seen first.
        if (iReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oValid = (state == OUT);
  assign oBusy  = (state != IDLE);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dataReg <= '0;
      idx     <= '0;
    end else if (clearAcc) begin
      dataReg <= iData;
      idx     <= '0;
    end else if (macEn) begin
      idx <= idx + 1'b1;
    end
  end

  assign xCur = dataReg[idx*data_width +: data_width];

  // Weights must not change under an in-flight MAC/ACT.
  assign wrOk = iWe && ((state == IDLE) || (state == OUT)) && (int'(iWAddr) < numRegs);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 2**addrW; i++) begin
        wRegs[i] <= '0;
      end
    end else if (wrOk) begin
      wRegs[iWAddr] <= iWData;
    end
  end

  for (genvar c = 0; c < out_channels; c++) begin : gLane
    logic [addrW-1:0]        wAddr;
    logic signed [accW-1:0]  preload;

    assign wAddr = addrW'(c * reservoir_size + int'(idx));

`ifdef READOUT_BIAS_EN
    logic signed [weight_size-1:0] bias;
    assign bias    = wRegs[addrW'(numWeights + c)];
    assign preload = {{(accW-weight_size){bias[weight_size-1]}}, bias};
`else
    assign preload = '0;
`endif

    readout_mac_lane #(
      .data_width  (data_width),
      .weight_size (weight_size),
      .acc_width   (accW),
      .act_shift   (act_shift),
      .out_width   (out_width)
    ) uLane (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iClear   (clearAcc),
      .iPreload (preload),
      .iMacEn   (macEn),
      .iX       (xCur),
      .iW       (wRegs[wAddr]),
      .iAct     (actEn),
      .oValue   (oValue[c*out_width +: out_width])
    );
  end

endmodule
